// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the even-ratio clock divider controller.
package clk_div_pkg;

   localparam int CNT_W_DEF        = 8;
   localparam int DEFAULT_HALF_DEF = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and divided-clock decode; all outputs come from registers.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             active,
   input  logic             load,
   input  logic             clear,
   input  logic [CNT_W-1:0] half,
   output logic             div_out,
   output logic             div_rise,
   output logic             period_end
);

   logic [CNT_W:0] cnt_q;
   logic [CNT_W:0] cnt_d;
   logic [CNT_W:0] last_cnt;

   // 2*half-1 at CNT_W+1 bits; half is never 0 while active
   assign last_cnt = {half, 1'b0} - (CNT_W+1)'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || load) begin
         cnt_d = '0;
      end else if (active) begin
         cnt_d = cnt_q + (CNT_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign div_out    = active && (cnt_q < {1'b0, half});
   assign div_rise   = active && (cnt_q == '0);
   assign period_end = active && (cnt_q == last_cnt);

endmodule

// File: rtl/clk_div_sched.sv
// Divider FSM and cfg handshake; ratio changes only at period boundaries.
// Optional period counter enabled by CLK_DIV_SCHED_PERIOD_CNT_EN.
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             run_en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             div_out,
   output logic             div_rise,
   output logic             busy,
   output logic [CNT_W-1:0] cur_half
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
   ,
   output logic [15:0]      period_cnt
`endif
);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cur_half_q;
   logic [CNT_W-1:0] cur_half_d;
   logic [CNT_W-1:0] pend_half_q;
   logic [CNT_W-1:0] pend_half_d;
   logic             core_load;
   logic             core_clear;
   logic             period_end;
   logic             xfer;

   assign busy      = (state_q != ST_IDLE);
   assign cfg_ready = (state_q != ST_DRAIN);
   assign xfer      = cfg_valid && cfg_ready;
   assign cur_half  = cur_half_q;

   always_comb begin
      state_d     = state_q;
      cur_half_d  = cur_half_q;
      pend_half_d = pend_half_q;
      core_load   = 1'b0;
      core_clear  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            core_clear = 1'b1;
            if (xfer) begin
               cur_half_d = cfg_half;
            end
            if (run_en && (cur_half_d != '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (period_end) begin
               core_load = 1'b1;
               if (xfer) begin
                  cur_half_d = cfg_half;
                  if ((cfg_half == '0) || !run_en) begin
                     state_d = ST_IDLE;
                  end
               end else if (!run_en) begin
                  state_d = ST_IDLE;
               end
            end else if (xfer) begin
               pend_half_d = cfg_half;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (period_end) begin
               core_load  = 1'b1;
               cur_half_d = pend_half_q;
               if ((pend_half_q == '0) || !run_en) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cur_half_q  <= CNT_W'(DEFAULT_HALF);
         pend_half_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_half_q  <= cur_half_d;
         pend_half_q <= pend_half_d;
      end
   end

   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk        (clk),
      .resetn     (resetn),
      .active     (busy),
      .load       (core_load),
      .clear      (core_clear),
      .half       (cur_half_q),
      .div_out    (div_out),
      .div_rise   (div_rise),
      .period_end (period_end)
   );

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
   logic [15:0] period_cnt_q;
   logic [15:0] period_cnt_d;

   always_comb begin
      period_cnt_d = period_cnt_q;
      if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
         period_cnt_d = '0;
      end else if (period_end && (period_cnt_q != 16'hFFFF)) begin
         period_cnt_d = period_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         period_cnt_q <= '0;
      end else begin
         period_cnt_q <= period_cnt_d;
      end
   end

   assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: constant vectors, corner sequences
// and random traffic against a queue-based behavioural model.
module tb_clk_div_sched;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       run_en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [7:0] cfg_half = 8'd0;
   logic       div_out;
   logic       div_rise;
   logic       busy;
   logic [7:0] cur_half;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model state
   bit m_run = 0;
   int m_pos = 0;
   int m_half = 1;
   int m_pc = 0;
   int pend_q[$];

   clk_div_sched dut (
      .clk       (clk),
      .resetn    (resetn),
      .run_en    (run_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_half  (cfg_half),
      .div_out   (div_out),
      .div_rise  (div_rise),
      .busy      (busy),
      .cur_half  (cur_half)
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
      ,
      .period_cnt (period_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit xfer;
      int newh;
      if (!resetn) begin
         m_run = 0; m_pos = 0; m_half = 1; m_pc = 0;
         pend_q.delete();
         return;
      end
      xfer = cfg_valid && (pend_q.size() == 0);
      if (!m_run) begin
         if (xfer) m_half = int'(cfg_half);
         if (run_en && m_half != 0) begin
            m_run = 1; m_pos = 0; m_pc = 0;
         end
      end else if (m_pos == 2 * m_half - 1) begin
         if (m_pc < 65535) m_pc++;
         newh = -1;
         if (xfer) newh = int'(cfg_half);
         else if (pend_q.size() != 0) newh = pend_q.pop_front();
         m_pos = 0;
         if (newh >= 0) begin
            m_half = newh;
            m_run = (newh != 0) && run_en;
         end else if (!run_en) begin
            m_run = 0;
         end
      end else begin
         m_pos++;
         if (xfer) pend_q.push_back(int'(cfg_half));
      end
   endtask

   task automatic cmp_model();
      chk("m_div_out", int'(div_out), int'(m_run && m_pos < m_half));
      chk("m_div_rise", int'(div_rise), int'(m_run && m_pos == 0));
      chk("m_busy", int'(busy), int'(m_run));
      chk("m_cfg_ready", int'(cfg_ready), int'(pend_q.size() == 0));
      chk("m_cur_half", int'(cur_half), m_half);
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
      chk("m_period_cnt", int'(period_cnt), m_pc);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cmp_model();
   endtask

   task automatic do_reset();
      resetn = 1'b0; run_en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
      step();
      resetn = 1'b1;
   endtask

   task automatic start_half(input int h);
      run_en = 1'b1; cfg_valid = 1'b1; cfg_half = 8'(h);
      step();
      cfg_valid = 1'b0;
   endtask

   typedef struct {
      bit rn; bit re; bit cv; int ch;
      bit e_do; bit e_ri; bit e_bu; bit e_rd; int e_cur;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int lows;
      int bcnt;
      int exp_pat[4];
      // default ratio 2, then stop at period end
      tbl.push_back(vec_t'{0,0,0,0, 0,0,0,1,1});
      tbl.push_back(vec_t'{1,1,0,0, 1,1,1,1,1});
      tbl.push_back(vec_t'{1,1,0,0, 0,0,1,1,1});
      tbl.push_back(vec_t'{1,1,0,0, 1,1,1,1,1});
      tbl.push_back(vec_t'{1,1,0,0, 0,0,1,1,1});
      tbl.push_back(vec_t'{1,0,0,0, 0,0,0,1,1});
      // H=3 loaded in IDLE together with run
      tbl.push_back(vec_t'{1,1,1,3, 1,1,1,1,3});
      tbl.push_back(vec_t'{1,1,0,0, 1,0,1,1,3});
      tbl.push_back(vec_t'{1,1,0,0, 1,0,1,1,3});
      tbl.push_back(vec_t'{1,1,0,0, 0,0,1,1,3});
      tbl.push_back(vec_t'{1,1,0,0, 0,0,1,1,3});
      tbl.push_back(vec_t'{1,1,0,0, 0,0,1,1,3});
      tbl.push_back(vec_t'{1,1,0,0, 1,1,1,1,3});
      tbl.push_back(vec_t'{1,0,0,0, 1,0,1,1,3});
      tbl.push_back(vec_t'{1,0,0,0, 1,0,1,1,3});
      tbl.push_back(vec_t'{1,0,0,0, 0,0,1,1,3});
      tbl.push_back(vec_t'{1,0,0,0, 0,0,1,1,3});
      tbl.push_back(vec_t'{1,0,0,0, 0,0,1,1,3});
      tbl.push_back(vec_t'{1,0,0,0, 0,0,0,1,3});

      #2;
      for (int i = 0; i < tbl.size(); i++) begin
         resetn = tbl[i].rn; run_en = tbl[i].re;
         cfg_valid = tbl[i].cv; cfg_half = 8'(tbl[i].ch);
         step();
         chk($sformatf("v%0d_div_out", i), int'(div_out), int'(tbl[i].e_do));
         chk($sformatf("v%0d_div_rise", i), int'(div_rise), int'(tbl[i].e_ri));
         chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].e_bu));
         chk($sformatf("v%0d_ready", i), int'(cfg_ready), int'(tbl[i].e_rd));
         chk($sformatf("v%0d_cur", i), int'(cur_half), tbl[i].e_cur);
      end

      // H=3 -> 2 requested at cnt=1: drains to the boundary
      do_reset();
      start_half(3);
      step();
      cfg_valid = 1'b1; cfg_half = 8'd2;
      step();
      cfg_valid = 1'b0;
      chk("drain_ready_low", int'(cfg_ready), 0);
      chk("drain_cur_old", int'(cur_half), 3);
      lows = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (cfg_ready) break;
         lows++;
      end
      chk("drain_len", lows, 4);
      chk("switch_cur", int'(cur_half), 2);
      chk("switch_rise", int'(div_rise), 1);
      exp_pat = '{1, 1, 0, 0};
      for (int i = 0; i < 4; i++) begin
         if (i != 0) step();
         chk($sformatf("h2_pat%0d", i), int'(div_out), exp_pat[i]);
      end

      // H=4, run_en dropped at cnt=2: period completes in full
      do_reset();
      start_half(4);
      step();
      step();
      run_en = 1'b0;
      lows = 0; bcnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (!busy) break;
         bcnt++;
         if (!div_out) lows++;
      end
      chk("stop_busy_cycles", bcnt, 5);
      chk("stop_low_cycles", lows, 4);
      chk("stop_div_out", int'(div_out), 0);

      // stop request (cfg_half=0) at cnt=0 with H=2
      do_reset();
      start_half(2);
      cfg_valid = 1'b1; cfg_half = 8'd0;
      step();
      cfg_valid = 1'b0;
      chk("zreq_busy_mid", int'(busy), 1);
      step();
      step();
      chk("zreq_busy_last", int'(busy), 1);
      step();
      chk("zreq_idle", int'(busy), 0);
      chk("zreq_cur", int'(cur_half), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("zreq_stay_idle", int'(busy), 0);
         chk("zreq_div_low", int'(div_out), 0);
      end

      // reset mid-period with H=5 at cnt=4
      do_reset();
      start_half(5);
      for (int i = 0; i < 4; i++) step();
      chk("h5_cnt4_high", int'(div_out), 1);
      resetn = 1'b0;
      step();
      chk("rst_div_out", int'(div_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cur", int'(cur_half), 1);
      chk("rst_ready", int'(cfg_ready), 1);
      resetn = 1'b1; run_en = 1'b1;
      step();
      chk("rel_rise", int'(div_rise), 1);
      chk("rel_busy", int'(busy), 1);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         resetn = ($urandom_range(0, 299) != 0);
         run_en = ($urandom_range(0, 9) != 0);
         cfg_valid = ($urandom_range(0, 4) == 0);
         cfg_half = ($urandom_range(0, 149) == 0) ? 8'd255
                                                  : 8'($urandom_range(0, 6));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Programmable even-ratio clock-divider controller for the clock-generation area.
- Generates a 50%-duty divided clock with ratio 2*H, where H is the half-period in clk cycles.
- Accepts new divide ratios over a valid/ready config interface and applies each one only at a period boundary, so no runt or glitched period is ever emitted.
- Sequences start/stop of the divided clock with a run-enable.

Parameters:
- CNT_W, 8, width of half-period field; legal H = 1 .. 2^CNT_W-1
- DEFAULT_HALF, 1, half-period loaded into cur_half at reset (ratio 2)

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- run_en  input  1  level; 1 = generate divided clock, 0 = stop at next period end
- cfg_valid  input  1  new half-period offered
- cfg_ready  output  1  controller can accept cfg
- cfg_half  input  CNT_W  requested half-period; 0 = stop request
- div_out  output  1  divided clock
- div_rise  output  1  one-cycle pulse in first cycle of each period (div_out just went high)
- busy  output  1  1 when state is RUN or DRAIN
- cur_half  output  CNT_W  half-period currently in effect

Behaviour:
- States: IDLE, RUN, DRAIN (RUN with a pending cfg). Registers: cnt (CNT_W+1 bits, 0 .. 2H-1), cur_half, pend_half.
- div_out = busy && (cnt < cur_half). div_rise = busy && cnt==0. Both are decoded from registers, with no combinational path from inputs.
- Reset (resetn=0 at clk edge, any state, including mid-period):
  - state=IDLE, cnt=0, pend_half=0, cur_half=DEFAULT_HALF.
  - div_out=0, div_rise=0, busy=0, cfg_ready=1 from the next cycle.
  - An interrupted period is discarded, never resumed.
- cfg_ready = (state != DRAIN). A transfer occurs when cfg_valid && cfg_ready.
- IDLE:
  - A cfg transfer loads cur_half=cfg_half in the same edge.
  - If run_en=1 and the effective cur_half != 0 (including a cfg accepted this edge), go to RUN with cnt=0. div_out and div_rise are high in the first RUN cycle.
  - If cur_half==0, stay IDLE regardless of run_en.
- RUN:
  - cnt increments every cycle. Period end is cnt == 2*cur_half-1, computed at CNT_W+1 bits with no overflow.
  - At period end:
    - cfg transfer in that same cycle: apply the new value immediately at this boundary (no DRAIN).
    - Otherwise, if run_en=0: go to IDLE, cnt=0.
    - Otherwise: cnt=0, new period.
  - A cfg transfer when not at period end: pend_half=cfg_half, go to DRAIN.
- DRAIN:
  - cnt continues. At period end: cur_half=pend_half, cnt=0.
  - If pend_half==0 or run_en==0, go to IDLE; otherwise go to RUN.
  - cfg_ready=0 throughout DRAIN. A held cfg_valid is accepted on the first cycle back in RUN/IDLE.
- run_en deassert mid-period: the period always completes, so the last low phase is full length.
- Priority at period end: reset > applying cfg (same-cycle or pending) > run_en=0 > continue.
- Latency:
  - cfg to effect: at most 2*H_old cycles.
  - run_en rise in IDLE to div_out high: 1 cycle.

Optional Feature:
- Macro CLK_DIV_SCHED_PERIOD_CNT_EN.
- When defined:
  - Adds output period_cnt [15:0], which increments on each completed period (period-end cycle while busy).
  - Saturates at 16'hFFFF.
  - Clears on reset and on IDLE->RUN.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Package clk_div_pkg: state enum typedef (IDLE, RUN, DRAIN), CNT_W default, DEFAULT_HALF default.
- Sub-module clk_div_core: the counter plus div_out/div_rise decode, with inputs load/clear/half and output period_end.
- The FSM and config handshake stay in clk_div_sched.

Test Plan:
- Reset with defaults, run_en=1 -> div_out toggles every cycle (1,0,1,0), div_rise on every high cycle, cur_half=1.
- In IDLE, cfg_half=3 accepted with run_en=1 -> 3 cycles high, 3 low, repeating; div_rise every 6 cycles.
- H=3 running, cfg_half=2 sent at cnt=1 -> cfg_ready low until cnt=5, then a 2-high/2-low pattern; no period shorter than 6 before the switch.
- H=4, run_en dropped at cnt=2 -> div_out completes 4 low cycles then stays 0; busy falls after cnt=7.
- cfg_half=0 accepted at cnt=0 with H=2 -> current 4-cycle period finishes, then IDLE, div_out=0; run_en=1 stays IDLE.
- resetn low at cnt=4 with H=5 -> next cycle div_out=0, busy=0, cur_half=1; on release with run_en=1, a fresh period starts (div_rise=1).
